// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type bit positions and the execute-to-memory bundle.
// Bundle field order matches the execute stage's packed bus.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 109;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_FWD_BUS_WD   = 38;

  localparam int LD_W   = 7;
  localparam int LD_LW  = 6;
  localparam int LD_LB  = 5;
  localparam int LD_LBU = 4;
  localparam int LD_LH  = 3;
  localparam int LD_LHU = 2;
  localparam int LD_LWL = 1;
  localparam int LD_LWR = 0;

  typedef struct packed {
    logic [LD_W-1:0] ld_inst;
    logic [31:0]     rt_value;
    logic            gr_we;
    logic [4:0]      dest;
    logic [31:0]     res;
    logic [31:0]     pc;
  } es_to_ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: byte/half extraction with extension and the
// unaligned-word merges, all combinational.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [LD_W-1:0] ld_inst,
  input  logic [1:0]      pos,
  input  logic [31:0]     data,
  input  logic [31:0]     rt,
  output logic [31:0]     result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] wl;
  logic [31:0] wr;

  always_comb begin
    byte_sel = data[7:0];
    wl       = data;
    wr       = data;
    unique case (pos)
      2'd0: begin
        byte_sel = data[7:0];
        wl       = {data[7:0], rt[23:0]};
        wr       = data;
      end
      2'd1: begin
        byte_sel = data[15:8];
        wl       = {data[15:0], rt[15:0]};
        wr       = {rt[31:24], data[31:8]};
      end
      2'd2: begin
        byte_sel = data[23:16];
        wl       = {data[23:0], rt[7:0]};
        wr       = {rt[31:16], data[31:16]};
      end
      2'd3: begin
        byte_sel = data[31:24];
        wl       = data;
        wr       = {rt[31:8], data[31:24]};
      end
    endcase
  end

  assign half_sel = pos[1] ? data[31:16] : data[15:0];

  always_comb begin
    result = '0;
    unique case (1'b1)
      ld_inst[LD_LW]:  result = data;
      ld_inst[LD_LB]:  result = {{24{byte_sel[7]}}, byte_sel};
      ld_inst[LD_LBU]: result = {24'd0, byte_sel};
      ld_inst[LD_LH]:  result = {{16{half_sel[15]}}, half_sel};
      ld_inst[LD_LHU]: result = {16'd0, half_sel};
      ld_inst[LD_LWL]: result = wl;
      ld_inst[LD_LWR]: result = wr;
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: pipeline register, valid/allowin handshake,
// SRAM read-data hold buffer for stalls, and the forwarding bus.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);

  es_to_ms_t   ms_bus;
  logic        ms_valid;
  logic        ms_ready_go;
  logic        entry;
  logic [31:0] rdata_buf;
  logic        rdata_buf_valid;
  logic [31:0] rdata_sel;
  logic [31:0] ld_result;
  logic [31:0] final_result;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign entry          = es_to_ms_valid && ms_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      ms_bus   <= '0;
    end else begin
      if (ms_allowin)
        ms_valid <= es_to_ms_valid;
      if (entry)
        ms_bus <= es_to_ms_t'(es_to_ms_bus);
    end
  end

  // SRAM data is only valid in the first resident cycle; hold it across a stall
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_buf       <= '0;
      rdata_buf_valid <= 1'b0;
    end else if (entry) begin
      rdata_buf_valid <= 1'b0;
    end else if (ms_valid && !rdata_buf_valid && !ms_allowin) begin
      rdata_buf       <= data_sram_rdata;
      rdata_buf_valid <= 1'b1;
    end
  end

  assign rdata_sel = rdata_buf_valid ? rdata_buf : data_sram_rdata;

  load_align u_align (
    .ld_inst (ms_bus.ld_inst),
    .pos     (ms_bus.res[1:0]),
    .data    (rdata_sel),
    .rt      (ms_bus.rt_value),
    .result  (ld_result)
  );

  assign final_result = (|ms_bus.ld_inst) ? ld_result : ms_bus.res;

  assign ms_to_ws_bus = {ms_bus.gr_we, ms_bus.dest, final_result, ms_bus.pc};
  assign ms_fwd_bus   = {ms_valid && ms_bus.gr_we, ms_bus.dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors, stall/reset
// sequences and randomized traffic against a behavioural model.
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [108:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [69:0]  ms_to_ws_bus;
  logic [31:0]  data_sram_rdata;
  logic [37:0]  ms_fwd_bus;

  int total;
  int bad;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_fwd_bus      (ms_fwd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  ld;
    logic [31:0] res;
    logic [31:0] rt;
    logic [31:0] rdata;
    logic [4:0]  dest;
    logic [31:0] exp;
  } vec_t;

  vec_t v[10];

  task automatic chk(input string name, input logic [69:0] act,
                     input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference load result from byte-lane arithmetic
  function automatic logic [31:0] ref_ld(input logic [6:0] ld,
      input logic [31:0] res, input logic [31:0] rt,
      input logic [31:0] data);
    int unsigned p;
    logic [31:0] b, h, lo_mask, hi_mask;
    p = res[1:0];
    b = (data >> (8 * p)) & 32'hFF;
    h = (data >> (16 * (p / 2))) & 32'hFFFF;
    lo_mask = 32'((64'd1 << (8 * (3 - p))) - 64'd1);
    hi_mask = ~(32'hFFFF_FFFF >> (8 * p));
    case (ld)
      7'b1000000: return data;
      7'b0100000: return b[7] ? (b | 32'hFFFF_FF00) : b;
      7'b0010000: return b;
      7'b0001000: return h[15] ? (h | 32'hFFFF_0000) : h;
      7'b0000100: return h;
      7'b0000010: return (data << (8 * (3 - p))) | (rt & lo_mask);
      7'b0000001: return (data >> (8 * p)) | (rt & hi_mask);
      default:    return res;
    endcase
  endfunction

  function automatic logic [108:0] mk_bus(input logic [6:0] ld,
      input logic [31:0] rt, input logic we, input logic [4:0] dest,
      input logic [31:0] res, input logic [31:0] pc);
    return {ld, rt, we, dest, res, pc};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // random-model state
  logic        mv;
  logic        mfirst;
  logic [6:0]  mld;
  logic [31:0] mres, mrt, mpc, mexp;
  logic        mwe;
  logic [4:0]  mdest;

  initial begin
    logic [31:0] hold;
    int unsigned k;
    logic [6:0]  rld;
    logic [31:0] rres, rrt, rpc;
    logic        rwe;
    logic [4:0]  rdest;

    total = 0;
    bad = 0;
    reset = 1'b1;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_rdata = '0;

    v[0] = '{7'b0100000, 32'h1003, 32'h0, 32'h80FF_1234, 5'd1, 32'hFFFF_FF80};
    v[1] = '{7'b0010000, 32'h1003, 32'h0, 32'h80FF_1234, 5'd2, 32'h0000_0080};
    v[2] = '{7'b0000010, 32'h2001, 32'hAABB_CCDD, 32'h1122_3344, 5'd3, 32'h3344_CCDD};
    v[3] = '{7'b0000001, 32'h2002, 32'hAABB_CCDD, 32'h1122_3344, 5'd4, 32'hAABB_1122};
    v[4] = '{7'b1000000, 32'h2000, 32'h0, 32'hCAFE_F00D, 5'd6, 32'hCAFE_F00D};
    v[5] = '{7'b0001000, 32'h2002, 32'h0, 32'h8001_7FFF, 5'd7, 32'hFFFF_8001};
    v[6] = '{7'b0000100, 32'h2000, 32'h0, 32'h8001_9ABC, 5'd8, 32'h0000_9ABC};
    v[7] = '{7'b0000000, 32'h1234, 32'h0, 32'h5555_AAAA, 5'd5, 32'h0000_1234};
    v[8] = '{7'b0000010, 32'h3000, 32'hAABB_CCDD, 32'h1122_3344, 5'd9, 32'h44BB_CCDD};
    v[9] = '{7'b0000001, 32'h3003, 32'hAABB_CCDD, 32'h1122_3344, 5'd10, 32'hAABB_CC11};

    // reset state
    do_reset();
    #1;
    chk("reset_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("reset_allowin", 70'(ms_allowin), 70'd1);
    chk("reset_fwd", 70'(ms_fwd_bus), 70'd0);
    chk("reset_ws_bus", ms_to_ws_bus, 70'd0);

    // back-to-back table vectors, each with its own rdata
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      ws_allowin = 1'b1;
      if (i < 10) begin
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(v[i].ld, v[i].rt, 1'b1, v[i].dest,
                              v[i].res, 32'hBFC0_0000 + 32'(4 * i));
      end else begin
        es_to_ms_valid = 1'b0;
      end
      if (i > 0) data_sram_rdata = v[i-1].rdata;
      #1;
      if (i > 0) begin
        chk($sformatf("vec%0d_valid", i - 1), 70'(ms_to_ws_valid), 70'd1);
        chk($sformatf("vec%0d_ws", i - 1), ms_to_ws_bus,
            {1'b1, v[i-1].dest, v[i-1].exp, 32'hBFC0_0000 + 32'(4 * (i - 1))});
        chk($sformatf("vec%0d_fwd", i - 1), 70'(ms_fwd_bus),
            70'({1'b1, v[i-1].dest, v[i-1].exp}));
      end
    end
    @(negedge clk);
    #1;
    chk("drain_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("drain_fwd37", 70'(ms_fwd_bus[37]), 70'd0);

    // lw stalled 3 cycles; SRAM data changes after the first cycle
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    ws_allowin = 1'b0;
    es_to_ms_bus = mk_bus(7'b1000000, 32'h0, 1'b1, 5'd12, 32'h400, 32'h100);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    data_sram_rdata = 32'h1234_5678;
    #1;
    hold = ms_to_ws_bus[63:32];
    chk("stall_first", 70'(hold), 70'h1234_5678);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      data_sram_rdata = 32'hDEAD_BEEF;
      if (c == 2) ws_allowin = 1'b1;
      #1;
      chk($sformatf("stall_hold%0d", c), 70'(ms_to_ws_bus[63:32]),
          70'h1234_5678);
      chk($sformatf("stall_valid%0d", c), 70'(ms_to_ws_valid), 70'd1);
      chk($sformatf("stall_allowin%0d", c), 70'(ms_allowin),
          70'(c == 2));
    end
    @(negedge clk);
    #1;
    chk("stall_left_once", 70'(ms_to_ws_valid), 70'd0);

    // reset during a stall discards the bundle
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    ws_allowin = 1'b0;
    es_to_ms_bus = mk_bus(7'b0, 32'h0, 1'b1, 5'd3, 32'h77, 32'h200);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 70'(ms_to_ws_valid), 70'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_stall_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("rst_stall_fwd37", 70'(ms_fwd_bus[37]), 70'd0);
    chk("rst_stall_allowin", 70'(ms_allowin), 70'd1);

    // randomized traffic against the behavioural model
    mv = 1'b0;
    mfirst = 1'b0;
    mld = '0; mres = '0; mrt = '0; mpc = '0; mexp = '0;
    mwe = 1'b0; mdest = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      k = $urandom_range(0, 7);
      rld = (k == 7) ? 7'd0 : 7'(1 << k);
      rres = $urandom;
      rrt = $urandom;
      rpc = $urandom;
      rwe = 1'($urandom);
      rdest = 5'($urandom);
      es_to_ms_valid = 1'($urandom);
      ws_allowin = ($urandom_range(0, 2) != 0);
      es_to_ms_bus = mk_bus(rld, rrt, rwe, rdest, rres, rpc);
      data_sram_rdata = $urandom;
      #1;
      chk("rnd_allowin", 70'(ms_allowin), 70'(!mv || ws_allowin));
      chk("rnd_valid", 70'(ms_to_ws_valid), 70'(mv));
      if (mv) begin
        if (mfirst)
          mexp = (mld == 0) ? mres : ref_ld(mld, mres, mrt, data_sram_rdata);
        mfirst = 1'b0;
        chk("rnd_ws_bus", ms_to_ws_bus, {mwe, mdest, mexp, mpc});
        chk("rnd_fwd", 70'(ms_fwd_bus), 70'({mwe, mdest, mexp}));
      end else begin
        chk("rnd_fwd37", 70'(ms_fwd_bus[37]), 70'd0);
      end
      @(posedge clk);
      if (!mv || ws_allowin) begin
        mv = es_to_ms_valid;
        if (es_to_ms_valid) begin
          mld = rld; mres = rres; mrt = rrt; mpc = rpc;
          mwe = rwe; mdest = rdest; mfirst = 1'b1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
